// File: rtl/mips_mem_arbiter.sv
// Two-port arbiter in front of the single-port MIPS unified memory.
// Port 0 has fixed priority, a starvation counter bounds port 1's wait, and read data is tagged back to the issuing port.
module mips_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("mips_mem_arbiter: RD_LATENCY must be in 1..4");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("mips_mem_arbiter: MAX_BURST must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic [3:0]            starve_cnt;
  logic                  rd_issue;
  logic                  rd_port;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_port;
  logic                  ret_vld;
  logic                  ret_port;

  // Grants are gated by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        m1_gnt = (starve_cnt == BURST_LIM);
        m0_gnt = !m1_gnt;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!m1_req || m1_gnt) begin
      starve_cnt <= 4'd0;
    end else if (m0_gnt && starve_cnt != BURST_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign rd_issue = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
  assign rd_port  = m1_gnt;

  generate
    if (RD_LATENCY == 1) begin : g_pipe_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_vld  <= '0;
          pipe_port <= '0;
        end else begin
          pipe_vld  <= rd_issue;
          pipe_port <= rd_port;
        end
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_vld  <= '0;
          pipe_port <= '0;
        end else begin
          pipe_vld  <= {pipe_vld[RD_LATENCY-2:0], rd_issue};
          pipe_port <= {pipe_port[RD_LATENCY-2:0], rd_port};
        end
      end
    end
  endgenerate

  assign ret_vld  = pipe_vld[RD_LATENCY-1];
  assign ret_port = pipe_port[RD_LATENCY-1];

  // Read data is steered only to the tagged port; the other port sees zero.
  assign m0_rvalid = ret_vld && !ret_port;
  assign m1_rvalid = ret_vld && ret_port;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: one instance at RD_LATENCY=1 and one at RD_LATENCY=3 share stimulus,
// each with its own memory delay line; a transaction-level model predicts grants and tagged returns.
module tb_mips_mem_arbiter;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

  logic m0_gnt_a, m1_gnt_a, m0_rvalid_a, m1_rvalid_a, mem_we_a;
  logic [31:0] m0_rdata_a, m1_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic m0_gnt_b, m1_gnt_b, m0_rvalid_b, m1_rvalid_b, mem_we_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1), .MAX_BURST(MAXB)) u_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_rdata(mem_rdata_a));

  mips_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3), .MAX_BURST(MAXB)) u_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b));

  // Memory content is a fixed function of address; 0x10 holds 0xDEADBEEF.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  logic [31:0] a_d1 = '0, b_d1 = '0, b_d2 = '0, b_d3 = '0;
  always @(posedge clk) begin
    a_d1 <= mem_addr_a;
    b_d1 <= mem_addr_b;
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end
  assign mem_rdata_a = memfn(a_d1);
  assign mem_rdata_b = memfn(b_d3);

  // Scoreboard and model state
  typedef struct { int due; bit port; logic [31:0] addr; } ret_t;
  ret_t q1[$];
  ret_t q3[$];
  int cyc = 0;
  int burst = 0;
  int checks = 0;
  int failures = 0;
  logic eg0_l, eg1_l;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                      input logic [31:0] d0, input logic r1, input logic w1, input logic [31:0] a1,
                      input logic [31:0] d1);
    logic e0, e1, ewe, v0a, v1a, v0b, v1b;
    logic [31:0] ea, ed, da, db;
    @(negedge clk);
    rst_n = rst; m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (rst) begin
      if (r0 && r1) begin
        e1 = (burst == MAXB);
        e0 = !e1;
      end else begin
        e0 = r0;
        e1 = r1;
      end
    end else begin
      q1.delete();
      q3.delete();
    end
    ewe = 1'b0; ea = '0; ed = '0;
    if (e0) begin ewe = w0; ea = a0; ed = d0; end
    else if (e1) begin ewe = w1; ea = a1; ed = d1; end
    check("a.m0_gnt", m0_gnt_a, e0);      check("b.m0_gnt", m0_gnt_b, e0);
    check("a.m1_gnt", m1_gnt_a, e1);      check("b.m1_gnt", m1_gnt_b, e1);
    check("a.mem_we", mem_we_a, ewe);     check("b.mem_we", mem_we_b, ewe);
    check("a.mem_addr", mem_addr_a, ea);  check("b.mem_addr", mem_addr_b, ea);
    check("a.mem_wdata", mem_wdata_a, ed); check("b.mem_wdata", mem_wdata_b, ed);
    v0a = 1'b0; v1a = 1'b0; da = '0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      if (q1[0].port) v1a = 1'b1; else v0a = 1'b1;
      da = memfn(q1[0].addr);
      void'(q1.pop_front());
    end
    v0b = 1'b0; v1b = 1'b0; db = '0;
    if (q3.size() > 0 && q3[0].due == cyc) begin
      if (q3[0].port) v1b = 1'b1; else v0b = 1'b1;
      db = memfn(q3[0].addr);
      void'(q3.pop_front());
    end
    check("a.m0_rvalid", m0_rvalid_a, v0a); check("a.m1_rvalid", m1_rvalid_a, v1a);
    check("a.m0_rdata", m0_rdata_a, v0a ? da : 32'h0);
    check("a.m1_rdata", m1_rdata_a, v1a ? da : 32'h0);
    check("b.m0_rvalid", m0_rvalid_b, v0b); check("b.m1_rvalid", m1_rvalid_b, v1b);
    check("b.m0_rdata", m0_rdata_b, v0b ? db : 32'h0);
    check("b.m1_rdata", m1_rdata_b, v1b ? db : 32'h0);
    // Model the effect of the coming edge.
    if (!rst) burst = 0;
    else if (!r1 || e1) burst = 0;
    else if (e0 && burst < MAXB) burst++;
    if ((e0 && !w0) || (e1 && !w1)) begin
      q1.push_back('{due: cyc + 1, port: e1, addr: ea});
      q3.push_back('{due: cyc + 3, port: e1, addr: ea});
    end
    eg0_l = e0; eg1_l = e1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic rst, r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic e0, e1, rv0, rv1; logic [31:0] rd;
  } vec_t;

  vec_t tbl[8];
  logic p0, p0_we, p1, p1_we;
  logic [31:0] p0_a, p0_d, p1_a, p1_d, pat_a, pat_b, a_addr, b_addr;
  int wait1, max_wait;

  initial begin
    // Reset with both requesting, release, single read, write passthrough.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = tbl[0];
    tbl[2] = tbl[0];
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, memfn(32'h100)};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      check("tbl.m0_gnt", m0_gnt_a, tbl[i].e0);
      check("tbl.m1_gnt", m1_gnt_a, tbl[i].e1);
      check("tbl.m0_rvalid", m0_rvalid_a, tbl[i].rv0);
      check("tbl.m1_rvalid", m1_rvalid_a, tbl[i].rv1);
      check("tbl.m0_rdata", m0_rdata_a, tbl[i].rv0 ? tbl[i].rd : 32'h0);
      if (i == 6) begin
        check("tbl.wr_we", mem_we_a, 1'b1);
        check("tbl.wr_addr", mem_addr_a, 32'h20);
        check("tbl.wr_data", mem_wdata_a, 32'hCAFE0001);
      end
    end

    // Starvation bound: both read every cycle.
    pat_a = '0; pat_b = '0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 1'b1, 1'b0, 32'h2000 + 32'(i * 4), 32'h0);
      pat_a[i] = m1_gnt_a;
      pat_b[i] = m1_gnt_b;
    end
    check("burst.pattern_a", pat_a, 32'h4210);
    check("burst.pattern_b", pat_b, 32'h4210);
    idle(4);

    // Interleaved reads at latency 3, no cross-delivery.
    a_addr = 32'h0000_0A00; b_addr = 32'h0000_0B00;
    step(1'b1, 1'b1, 1'b0, a_addr, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, b_addr, 32'h0);
    idle(1);
    idle(1);
    check("ilv.m0_rvalid", m0_rvalid_b, 1'b1);
    check("ilv.m0_rdata", m0_rdata_b, memfn(a_addr));
    check("ilv.m1_rvalid_t3", m1_rvalid_b, 1'b0);
    idle(1);
    check("ilv.m1_rvalid", m1_rvalid_b, 1'b1);
    check("ilv.m1_rdata", m1_rdata_b, memfn(b_addr));
    check("ilv.m0_rvalid_t4", m0_rvalid_b, 1'b0);
    idle(2);

    // Reset pulse while a read is in flight.
    step(1'b1, 1'b1, 1'b0, 32'h0000_0C00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("rst.m0_rvalid_b", m0_rvalid_b, 1'b0);
      check("rst.m0_rvalid_a", m0_rvalid_a, 1'b0);
    end

    // Random traffic; requesters hold until granted, occasionally cancel.
    p0 = 1'b0; p1 = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_a = '0; p0_d = '0; p1_a = '0; p1_d = '0;
    wait1 = 0; max_wait = 0;
    for (int i = 0; i < 500; i++) begin
      logic rst;
      rst = ($urandom_range(0, 79) != 0);
      if (!p0 && $urandom_range(0, 9) < 7) begin
        p0 = 1'b1; p0_we = ($urandom_range(0, 3) == 0); p0_a = $urandom; p0_d = $urandom;
      end else if (p0 && $urandom_range(0, 19) == 0) p0 = 1'b0;
      if (!p1 && $urandom_range(0, 9) < 5) begin
        p1 = 1'b1; p1_we = ($urandom_range(0, 2) == 0); p1_a = $urandom; p1_d = $urandom;
      end else if (p1 && $urandom_range(0, 29) == 0) p1 = 1'b0;
      step(rst, p0, p0_we, p0_a, p0_d, p1, p1_we, p1_a, p1_d);
      if (rst && p1 && !eg1_l) wait1++;
      else wait1 = 0;
      if (wait1 > max_wait) max_wait = wait1;
      if (eg0_l) p0 = 1'b0;
      if (eg1_l) p1 = 1'b0;
    end
    check("rand.m1_max_wait_le_4", 32'(max_wait <= MAXB), 32'h1);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
